// File: rtl/tl_buffer_pkg.sv
// Shared constants and width helpers for the TileLink-style channel buffer.
package tl_buffer_pkg;

    localparam int DEF_NCH   = 5;
    localparam int DEF_W     = 64;
    localparam int DEF_DEPTH = 2;
    localparam bit DEF_PIPE  = 1'b0;
    localparam bit DEF_FLOW  = 1'b0;

    // Width of an occupancy counter able to hold 0..depth; at least one bit
    // so a DEPTH=0 (wire) configuration still has a legal count port.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Width of a storage pointer indexing 0..depth-1; at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tl_chan_queue.sv
// Single-channel ready/valid queue with optional pipe and flow bypass.
module tl_chan_queue
    import tl_buffer_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit PIPE     = DEF_PIPE,
    parameter bit FLOW     = DEF_FLOW,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int CW      = cnt_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          almost_full
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign in_ready    = reset & out_ready;
            assign out_valid   = reset & in_valid;
            assign out_data    = in_data;
            assign count       = '0;
            assign almost_full = 1'b0;
        end else begin : g_fifo
            localparam int PW = ptr_width(DEPTH);
            localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
            localparam logic [CW-1:0] FULL = CW'(DEPTH);

            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] wr_ptr;
            logic [PW-1:0] rd_ptr;
            logic [CW-1:0] cnt;
            logic          is_full;
            logic          is_empty;
            logic          enq;
            logic          deq;
            logic          bypass;
            logic          do_write;
            logic          do_read;

            assign is_full  = (cnt == FULL);
            assign is_empty = (cnt == '0);

            // Ready never depends on in_valid; PIPE only adds out_ready.
            assign in_ready  = reset & (~is_full | (PIPE & out_ready & is_full));
            assign out_valid = reset & (~is_empty | (FLOW & in_valid & is_empty));
            assign out_data  = (FLOW && is_empty) ? in_data : mem[rd_ptr];

            assign enq      = in_valid & in_ready;
            assign deq      = out_valid & out_ready;
            assign bypass   = FLOW & is_empty & enq & deq;
            assign do_write = enq & ~bypass;
            assign do_read  = deq & ~bypass;

            assign count       = cnt;
            assign almost_full = reset & (int'(cnt) >= AF_LEVEL);

            // Storage array is written on accepted, non-bypassed input; never cleared.
            always_ff @(posedge clock) begin
                if (do_write) begin
                    mem[wr_ptr] <= in_data;
                end
            end

            // Pointer and occupancy bookkeeping with non-power-of-two wrap.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (do_write) begin
                        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    end
                    if (do_read) begin
                        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                    end
                    case ({do_write, do_read})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tl_channel_buffer.sv
// NCH independent channel queues sharing one clock and reset.
module tl_channel_buffer
    import tl_buffer_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int W        = DEF_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit PIPE     = DEF_PIPE,
    parameter bit FLOW     = DEF_FLOW,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int CW      = cnt_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*W-1:0]  in_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*W-1:0]  out_data,
    output logic [NCH*CW-1:0] count,
    output logic [NCH-1:0]    almost_full
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        tl_chan_queue #(
            .W        (W),
            .DEPTH    (DEPTH),
            .PIPE     (PIPE),
            .FLOW     (FLOW),
            .AF_LEVEL (AF_LEVEL)
        ) u_queue (
            .clock       (clock),
            .reset       (reset),
            .in_valid    (in_valid[i]),
            .in_ready    (in_ready[i]),
            .in_data     (in_data[i*W +: W]),
            .out_valid   (out_valid[i]),
            .out_ready   (out_ready[i]),
            .out_data    (out_data[i*W +: W]),
            .count       (count[i*CW +: CW]),
            .almost_full (almost_full[i])
        );
    end

endmodule

// File: doc/tl_channel_buffer.md
TL_CHANNEL_BUFFER -- requirements
Module: tl_channel_buffer

Interface
REQ-001 SHALL have parameter NCH, default 5, number of independent channels (A..E style).
REQ-002 SHALL have parameter W, default 64, payload bits per channel (packed channel fields).
REQ-003 SHALL have parameter DEPTH, default 2, entries per channel; 0 = pure wire passthrough, otherwise >=1, any integer (not only powers of 2).
REQ-004 SHALL have parameter PIPE, default 0, 1 = enq may fire when full if the same-cycle deq fires.
REQ-005 SHALL have parameter FLOW, default 0, 1 = an empty queue forwards input to output in the same cycle.
REQ-006 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold.
REQ-007 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have port in_valid, input, NCH, per-channel producer valid.
REQ-010 SHALL have port in_ready, output, NCH, per-channel producer ready.
REQ-011 SHALL have port in_data, input, NCH*W, channel i occupies bits [i*W +: W].
REQ-012 SHALL have port out_valid, output, NCH, per-channel consumer valid.
REQ-013 SHALL have port out_ready, input, NCH, per-channel consumer ready.
REQ-014 SHALL have port out_data, output, NCH*W, same packing as in_data.
REQ-015 SHALL have port count, output, NCH*CW, occupancy per channel, where CW = $clog2(DEPTH+1).
REQ-016 SHALL have port almost_full, output, NCH, asserted when count >= AF_LEVEL.

Function
REQ-017 Channels SHALL be fully independent; no ordering or backpressure coupling between channels.
REQ-018 Enq fires when in_valid & in_ready; deq fires when out_valid & out_ready; data order SHALL be FIFO per channel.
REQ-019 in_ready SHALL be (count < DEPTH) | (PIPE & out_ready & count == DEPTH).
REQ-020 out_valid SHALL be (count > 0) | (FLOW & in_valid & count == 0).
REQ-021 out_data SHALL be the head entry when count > 0; when FLOW and count == 0 it SHALL be in_data combinationally.
REQ-022 FLOW bypass with both enq and deq firing at count 0 SHALL NOT write storage; count SHALL stay 0.
REQ-023 Latency with FLOW=0: data written in cycle N is first visible at out_data in cycle N+1.
REQ-024 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 count SHALL be +1 on enq only, -1 on deq only, and unchanged on simultaneous enq and deq, including full with PIPE.
REQ-026 count SHALL never exceed DEPTH or underflow; in_valid while full and not PIPE-accepted SHALL be held off.
REQ-027 out_data SHALL stay stable while out_valid & !out_ready, for stored entries.
REQ-028 DEPTH=0 SHALL make out_* = in_* and in_ready = out_ready, with count = 0 and almost_full = 0.
REQ-029 The block SHALL have no combinational path in_valid->in_ready; FLOW adds in_valid->out_valid/out_data, and PIPE adds out_ready->in_ready.

Reset
REQ-030 While reset=0 at a rising edge: pointers 0, count 0, stored data not cleared.
REQ-031 While reset is low, in_ready and out_valid SHALL be forced 0, almost_full SHALL be 0, and out_data is don't-care.
REQ-032 Reset asserted mid-traffic SHALL discard all entries; the first cycle after release shows empty queues.

Structure
REQ-033 A shared package tl_buffer_pkg SHALL hold the count-width function and default parameter constants.
REQ-034 One sub-module tl_chan_queue (single channel: W, DEPTH, PIPE, FLOW) SHALL be instantiated NCH times via generate.
REQ-035 Storage SHALL be a register array, with no memory macros.

Verification
REQ-036 Fill/drain, with NCH=2, W=8, DEPTH=2, defaults: enq 0x11, 0x22 on ch0 with out_ready=0 -> count=2, in_ready=0, almost_full=1; then out_ready=1 -> 0x11 then 0x22 on consecutive cycles, count 2->1->0.
REQ-037 PIPE=1, ch1 full with {0xA0, 0xA1}: in_valid=1 (0xA2) and out_ready=1 -> 0xA0 dequeues, 0xA2 accepted, count stays 2, next outputs 0xA1, 0xA2.
REQ-038 FLOW=1, empty ch0, in_valid=1 (0x5A), out_ready=1 -> out_valid=1, out_data=0x5A in the same cycle, count stays 0.
REQ-039 Wrap with DEPTH=3: stream 10 words 0x00..0x09 with random out_ready -> output order 0x00..0x09, and count never >3.
REQ-040 Reset mid-operation: with count=1 on ch0 and 2 on ch1, drive reset=0 for one cycle -> in_ready=0 and out_valid=0 during reset; after release count=0 on all channels and in_ready=1.
REQ-041 Independence: hold ch0 out_ready=0 until full while ch1 streams at out_ready=1 -> ch1 throughput 1 word/cycle, unaffected.
